// File: rtl/lcd_update_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : lcd_update_arbiter
// Brief    : Round-robin arbiter that lets three requesters share one LCD
//            display block. It latches the winner's X/Y value and runs a
//            four-phase LCDUpdate/LCDAck handshake, with LCDAck
//            synchronised into the Clk domain.
//            Optional macro LCD_ARB_HOLD_EN adds a HOLD state that keeps
//            each granted value on the display for HOLD_CYCLES clocks.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_update_arbiter #(
    parameter logic [23:0] HOLD_CYCLES = 24'd5000000
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [2:0] Req,
    input  logic [9:0] DataIn_X0,
    input  logic [9:0] DataIn_X1,
    input  logic [9:0] DataIn_X2,
    input  logic [9:0] DataIn_Y0,
    input  logic [9:0] DataIn_Y1,
    input  logic [9:0] DataIn_Y2,
    output logic [2:0] Grant,
    output logic [2:0] Done,
    output logic [9:0] DataOut_X,
    output logic [9:0] DataOut_Y,
    output logic       LCDUpdate,
    input  logic       LCDAck,
    output logic       Busy
);

    localparam logic [2:0] c_st_idle     = 3'd0;
    localparam logic [2:0] c_st_latch    = 3'd1;
    localparam logic [2:0] c_st_issue    = 3'd2;
    localparam logic [2:0] c_st_wait_ack = 3'd3;
    localparam logic [2:0] c_st_wait_rel = 3'd4;
`ifdef LCD_ARB_HOLD_EN
    localparam logic [2:0] c_st_hold     = 3'd5;
    // A zero hold request degenerates to a single HOLD cycle instead of wrapping.
    localparam logic [23:0] c_hold_load  = (HOLD_CYCLES == 24'd0) ? 24'd0 : (HOLD_CYCLES - 24'd1);
`endif

    logic [2:0] r_state;
    logic [1:0] r_last;
    logic [1:0] r_win;
    logic [2:0] r_grant;
    logic [2:0] r_done;
    logic [9:0] r_x;
    logic [9:0] r_y;
    logic       r_update;
    logic       r_ack_meta;
    logic       r_ack_s;
`ifdef LCD_ARB_HOLD_EN
    logic [23:0] r_hold_cnt;
`endif

    logic       w_win_valid;
    logic [1:0] w_win_idx;
    logic [9:0] w_sel_x;
    logic [9:0] w_sel_y;

    function automatic logic [2:0] f_onehot(input logic [1:0] idx);
        logic [2:0] v;
        v = 3'b000;
        case (idx)
            2'd0:    v = 3'b001;
            2'd1:    v = 3'b010;
            2'd2:    v = 3'b100;
            default: v = 3'b000;
        endcase
        return v;
    endfunction

    // LCDAck comes from the divided display clock; two flops before any decision.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_ack_meta <= 1'b0;
            r_ack_s    <= 1'b0;
        end else begin
            r_ack_meta <= LCDAck;
            r_ack_s    <= r_ack_meta;
        end
    end

    // Round-robin pick: search starts one past the last served requester.
    always_comb begin
        w_win_valid = |Req;
        w_win_idx   = 2'd0;
        case (r_last)
            2'd0: begin
                if (Req[1])      w_win_idx = 2'd1;
                else if (Req[2]) w_win_idx = 2'd2;
                else             w_win_idx = 2'd0;
            end
            2'd1: begin
                if (Req[2])      w_win_idx = 2'd2;
                else if (Req[0]) w_win_idx = 2'd0;
                else             w_win_idx = 2'd1;
            end
            default: begin
                if (Req[0])      w_win_idx = 2'd0;
                else if (Req[1]) w_win_idx = 2'd1;
                else             w_win_idx = 2'd2;
            end
        endcase
    end

    // Data selector for the requester that won the last arbitration.
    always_comb begin
        w_sel_x = DataIn_X0;
        w_sel_y = DataIn_Y0;
        case (r_win)
            2'd1: begin
                w_sel_x = DataIn_X1;
                w_sel_y = DataIn_Y1;
            end
            2'd2: begin
                w_sel_x = DataIn_X2;
                w_sel_y = DataIn_Y2;
            end
            default: begin
                w_sel_x = DataIn_X0;
                w_sel_y = DataIn_Y0;
            end
        endcase
    end

    // Transaction sequencer: arbitrate, latch, issue, four-phase handshake.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state    <= c_st_idle;
            r_last     <= 2'd2;
            r_win      <= 2'd0;
            r_grant    <= 3'b000;
            r_done     <= 3'b000;
            r_x        <= 10'd0;
            r_y        <= 10'd0;
            r_update   <= 1'b0;
`ifdef LCD_ARB_HOLD_EN
            r_hold_cnt <= 24'd0;
`endif
        end else begin
            r_done <= 3'b000;
            case (r_state)
                c_st_idle: begin
                    // Grant is kept through the Done cycle and only dropped here.
                    r_grant <= 3'b000;
                    if (w_win_valid) begin
                        r_grant <= f_onehot(w_win_idx);
                        r_win   <= w_win_idx;
                        r_state <= c_st_latch;
                    end
                end
                c_st_latch: begin
                    r_x     <= w_sel_x;
                    r_y     <= w_sel_y;
                    r_last  <= r_win;
                    r_state <= c_st_issue;
                end
                c_st_issue: begin
                    r_update <= 1'b1;
                    r_state  <= c_st_wait_ack;
                end
                c_st_wait_ack: begin
                    // A stale high ack is accepted here; the low phase is still required.
                    if (r_ack_s) begin
                        r_update <= 1'b0;
                        r_state  <= c_st_wait_rel;
                    end
                end
                c_st_wait_rel: begin
                    if (!r_ack_s) begin
                        r_done <= f_onehot(r_win);
`ifdef LCD_ARB_HOLD_EN
                        r_hold_cnt <= c_hold_load;
                        r_state    <= c_st_hold;
`else
                        r_state    <= c_st_idle;
`endif
                    end
                end
`ifdef LCD_ARB_HOLD_EN
                c_st_hold: begin
                    r_grant <= 3'b000;
                    if (r_hold_cnt == 24'd0) begin
                        r_state <= c_st_idle;
                    end else begin
                        r_hold_cnt <= r_hold_cnt - 24'd1;
                    end
                end
`endif
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign Grant     = r_grant;
    assign Done      = r_done;
    assign DataOut_X = r_x;
    assign DataOut_Y = r_y;
    assign LCDUpdate = r_update;
    assign Busy      = (r_state != c_st_idle);

endmodule
`default_nettype wire

// File: tb/tb_lcd_update_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_update_arbiter
// Brief    : Self-checking bench for lcd_update_arbiter: transaction-level
//            reference thread, display-side ack responder, directed cases
//            and randomized requesters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_update_arbiter;

`ifdef LCD_ARB_HOLD_EN
    localparam int c_hold = 8;
`else
    localparam int c_hold = 0;
`endif
    localparam logic [23:0] c_hold_param = (c_hold == 0) ? 24'd5000000 : 24'(c_hold);

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] req = 3'b000;
    logic [9:0] dx [3];
    logic [9:0] dy [3];
    logic [2:0] grant;
    logic [2:0] done;
    logic [9:0] out_x;
    logic [9:0] out_y;
    logic       upd;
    logic       ack = 1'b0;
    logic       busy;

    int errors = 0;
    int checks = 0;

    lcd_update_arbiter #(.HOLD_CYCLES(c_hold_param)) dut (
        .Clk       (clk),
        .Rst       (rst),
        .Req       (req),
        .DataIn_X0 (dx[0]),
        .DataIn_X1 (dx[1]),
        .DataIn_X2 (dx[2]),
        .DataIn_Y0 (dy[0]),
        .DataIn_Y1 (dy[1]),
        .DataIn_Y2 (dy[2]),
        .Grant     (grant),
        .Done      (done),
        .DataOut_X (out_x),
        .DataOut_Y (out_y),
        .LCDUpdate (upd),
        .LCDAck    (ack),
        .Busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    logic [2:0] e_grant = 3'b000;
    logic [2:0] e_done  = 3'b000;
    logic [9:0] e_x     = 10'd0;
    logic [9:0] e_y     = 10'd0;
    logic       e_upd   = 1'b0;
    logic       e_busy  = 1'b0;
    int         m_last  = 2;
    logic       m_s1 = 1'b0, m_s2 = 1'b0, m_acks = 1'b0, m_abort = 1'b0;
    logic [2:0] m_req = 3'b000;

    function automatic int rr(input logic [2:0] r, input int last);
        int idx;
        for (int k = 1; k <= 3; k++) begin
            idx = (last + k) % 3;
            if (r[idx]) return idx;
        end
        return 0;
    endfunction

    // One clock edge as seen by the design; ackS is LCDAck delayed two edges.
    task automatic m_step();
        @(posedge clk or posedge rst);
        if (rst) begin
            m_s1 = 1'b0; m_s2 = 1'b0; m_acks = 1'b0; m_abort = 1'b1;
        end else begin
            m_acks = m_s2; m_s2 = m_s1; m_s1 = ack; m_req = req;
        end
    endtask

    task automatic m_reset();
        e_grant = 3'b000; e_done = 3'b000; e_x = 10'd0; e_y = 10'd0;
        e_upd = 1'b0; e_busy = 1'b0; m_last = 2; m_abort = 1'b0;
    endtask

    // Each pass of the loop starts at an edge where the arbiter is idle.
    initial begin : model
        int win;
        forever begin
            m_step();
            if (m_abort) begin
                m_reset();
            end else begin
                e_done  = 3'b000;
                e_grant = 3'b000;
                if (m_req != 3'b000) begin
                    win = rr(m_req, m_last);
                    e_grant = 3'(1 << win);
                    e_busy  = 1'b1;
                    m_step();
                    if (!m_abort) begin
                        e_x = dx[win]; e_y = dy[win]; m_last = win;
                        m_step();
                    end
                    if (!m_abort) e_upd = 1'b1;
                    while (!m_abort) begin
                        m_step();
                        if (!m_abort && m_acks) begin e_upd = 1'b0; break; end
                    end
                    while (!m_abort) begin
                        m_step();
                        if (!m_abort && !m_acks) begin
                            e_done = 3'(1 << win); e_busy = 1'b0; break;
                        end
                    end
`ifdef LCD_ARB_HOLD_EN
                    if (!m_abort) begin
                        e_busy = 1'b1;
                        for (int i = 0; i < c_hold; i++) begin
                            m_step();
                            if (m_abort) break;
                            if (i == 0) begin e_done = 3'b000; e_grant = 3'b000; end
                        end
                        if (!m_abort) e_busy = 1'b0;
                    end
`endif
                    if (m_abort) m_reset();
                end
            end
        end
    end

    // Every cycle: DUT outputs against the model.
    always @(negedge clk) begin
        chk("m_grant",  int'(grant), int'(e_grant));
        chk("m_done",   int'(done),  int'(e_done));
        chk("m_out_x",  int'(out_x), int'(e_x));
        chk("m_out_y",  int'(out_y), int'(e_y));
        chk("m_update", int'(upd),   int'(e_upd));
        chk("m_busy",   int'(busy),  int'(e_busy));
    end

    // ---------------- display-side ack responder ----------------
    int   ack_dly = 2;
    logic stale_req = 1'b0;
    logic stale_prev = 1'b0;
    logic stale_hold = 1'b0;
    int   hi_cnt = 0, lo_cnt = 0, ack_falls = 0;

    // Four-phase responder with a programmable delay and a stale-ack mode.
    always @(negedge clk) begin
        if (stale_req && !stale_prev) begin
            ack = 1'b1; stale_hold = 1'b1;
        end
        stale_prev = stale_req;
        if (stale_hold) begin
            if (upd) stale_hold = 1'b0;
            hi_cnt = 0; lo_cnt = 0;
        end else if (upd) begin
            lo_cnt = 0;
            if (hi_cnt >= ack_dly) ack = 1'b1;
            else hi_cnt++;
        end else begin
            hi_cnt = 0;
            if (ack) begin
                if (lo_cnt >= ack_dly) begin ack = 1'b0; ack_falls++; lo_cnt = 0; end
                else lo_cnt++;
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic wait_done(input logic [2:0] mask, input int budget, input string name);
        int n;
        n = 0;
        while (done !== mask && n < budget) begin @(negedge clk); n++; end
        chk({name, "_done"}, int'(done), int'(mask));
    endtask

    task automatic wait_upd(input int budget, input string name);
        int n;
        n = 0;
        while (upd !== 1'b1 && n < budget) begin @(negedge clk); n++; end
        chk({name, "_update_seen"}, int'(upd), 1);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy || upd || ack || done != 3'b000) && n < 300) begin @(negedge clk); n++; end
        chk({name, "_idle_reached"}, int'(n < 300), 1);
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [2:0] exp_seq [4];
    logic [2:0] got;

    initial begin : stim
        int n;
        logic busy_low;
        exp_seq = '{3'b001, 3'b010, 3'b100, 3'b001};
        for (int i = 0; i < 3; i++) begin dx[i] = 10'd0; dy[i] = 10'd0; end

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_grant",  int'(grant), 0);
        chk("rst_done",   int'(done),  0);
        chk("rst_update", int'(upd),   0);
        chk("rst_out_x",  int'(out_x), 0);
        chk("rst_out_y",  int'(out_y), 0);
        chk("rst_busy",   int'(busy),  0);
        rst = 1'b0;
        @(negedge clk);

        // Single request: latency, latched data, done pulse
        dx[0] = 10'd320; dy[0] = 10'd240; req = 3'b001;
        n = 0;
        do begin @(negedge clk); n++; end while (!upd && n < 20);
        chk("t1_latency", n, 3);
        chk("t1_grant",   int'(grant), 1);
        chk("t1_out_x",   int'(out_x), 320);
        chk("t1_out_y",   int'(out_y), 240);
        chk("t1_model_x", int'(e_x), 320);
        wait_done(3'b001, 60, "t1");
        req = 3'b000;
        @(negedge clk);
        chk("t1_done_one_cycle", int'(done), 0);
        wait_idle("t1");

        // All requesting: rotation 0,1,2,0 from reset
        pulse_reset();
        req = 3'b111;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (done == 3'b000 && n < 200) begin @(negedge clk); n++; end
            got = done;
            chk("t2_done_seq", int'(got), int'(exp_seq[k]));
            chk("t2_grant_in_done_cycle", int'(grant), int'(exp_seq[k]));
            if (k == 3) req = 3'b000;
            @(negedge clk);
        end
        wait_idle("t2");

        // Requester withdraws during WAIT_ACK
        req = 3'b010;
        wait_upd(20, "t3");
        req = 3'b000;
        wait_done(3'b010, 60, "t3");
        @(negedge clk);
        chk("t3_busy_after", int'(busy), (c_hold > 0) ? 1 : 0);
        wait_idle("t3");

        // Reset in the middle of the handshake
        dx[2] = 10'd777; dy[2] = 10'd123;
        req = 3'b100;
        wait_upd(20, "t4");
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t4_update_async", int'(upd), 0);
        chk("t4_grant_async",  int'(grant), 0);
        chk("t4_out_x_async",  int'(out_x), 0);
        req = 3'b000;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t4_no_done", int'(done), 0);
        end
        rst = 1'b0;
        wait_idle("t4_pre");
        req = 3'b100;
        wait_done(3'b100, 60, "t4");
        chk("t4_out_x", int'(out_x), 777);
        chk("t4_out_y", int'(out_y), 123);
        req = 3'b000;
        wait_idle("t4");

        // Stale ack already high before the request
        stale_req = 1'b1;
        repeat (4) @(negedge clk);
        n = ack_falls;
        req = 3'b001;
        wait_done(3'b001, 80, "t5");
        chk("t5_ack_fell_before_done", int'(ack_falls > n), 1);
        req = 3'b000;
        stale_req = 1'b0;
        wait_idle("t5");

`ifdef LCD_ARB_HOLD_EN
        // Hold window between consecutive updates
        req = 3'b011;
        n = 0;
        while (done == 3'b000 && n < 200) begin @(negedge clk); n++; end
        chk("t6_first_done", int'(done != 3'b000), 1);
        req = req & ~done;
        n = 0;
        busy_low = 1'b0;
        while (!upd && n < 200) begin
            @(negedge clk); n++;
            if (n < c_hold && !busy) busy_low = 1'b1;
        end
        chk("t6_gap_ge_hold_plus_3", int'(n >= c_hold + 3), 1);
        chk("t6_busy_in_hold", int'(busy_low), 0);
        n = 0;
        while (done == 3'b000 && n < 200) begin @(negedge clk); n++; end
        chk("t6_second_done", int'(done != 3'b000), 1);
        req = 3'b000;
        wait_idle("t6");
`else
        busy_low = 1'b0;
`endif

        // Randomized requesters, ack delays and occasional resets
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (req[i]) begin
                    if (done[i]) req[i] = 1'b0;
                    else if (grant[i] && $urandom_range(0, 39) == 0) req[i] = 1'b0;
                end else begin
                    dx[i] = 10'($urandom_range(0, 1023));
                    dy[i] = 10'($urandom_range(0, 1023));
                    if ($urandom_range(0, 3) == 0) req[i] = 1'b1;
                end
            end
            if (!busy && !upd) ack_dly = int'($urandom_range(0, 4));
            if ($urandom_range(0, 799) == 0) pulse_reset();
        end
        req = 3'b000;
        wait_idle("rand");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
